// File: rtl/lcd_16207_sequencer.sv
// lcd_16207_sequencer: HD44780/16207 pin sequencer; runs the power-on init ROM, then times RS/RW/E for each byte.
// Latency: T_SETUP+T_EPW+T_HOLD strobe plus a completion wait per byte (busy-flag poll when LCD_BUSY_POLL_EN is defined).
// Backpressure: cmd_ready only in IDLE after init, low from acceptance until the panel has finished the byte.
module lcd_16207_sequencer #(
    parameter int T_SETUP    = 4,
    parameter int T_EPW      = 12,
    parameter int T_HOLD     = 4,
    parameter int T_PWRUP    = 750000,
    parameter int T_EXEC     = 2000,
    parameter int T_CLEAR    = 80000,
    parameter int POLL_LIMIT = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       timeout_err,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_data_out,
    output logic       LCD_data_oe,
    input  logic [7:0] LCD_data_in
);
    localparam logic [31:0] PWRUP_TC = 32'(T_PWRUP - 1);
    localparam logic [31:0] SETUP_TC = 32'(T_SETUP - 1);
    localparam logic [31:0] EPW_TC   = 32'(T_EPW - 1);
    localparam logic [31:0] HOLD_TC  = 32'(T_HOLD - 1);

    typedef enum logic [3:0] {
        PWR_WAIT, INIT_LOAD, IDLE, W_SETUP, W_EHI, W_HOLD,
        WAIT_DONE, P_SETUP, P_EHI, P_HOLD
    } state_t;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic       oe;
        logic [7:0] d;
    } pins_t;

    state_t      state;
    pins_t       pins;
    logic [31:0] cnt;
    logic [31:0] wait_len;
    logic [2:0]  rom_idx;
    logic        lat_rs;
    logic [7:0]  lat_data;
    logic        fixed_wait;
    logic        wait_fin;
    logic        unused_din;

`ifdef LCD_BUSY_POLL_EN
    localparam int POLL_W = ($clog2(POLL_LIMIT + 1) > 17) ? $clog2(POLL_LIMIT + 1) : 17;
    localparam logic [POLL_W-1:0] LIMIT_TC = POLL_W'(POLL_LIMIT - 1);
    logic [POLL_W-1:0] poll_cnt;
    logic              busy_smp;
    assign unused_din = ^{LCD_data_in[6:0], 32'(T_EXEC)};
`else
    logic is_clear;
    assign is_clear   = !lat_rs && (lat_data == 8'h01 || lat_data == 8'h02);
    assign unused_din = ^{LCD_data_in, 32'(POLL_LIMIT)};
`endif

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd3:    init_rom = 8'h0C;
            3'd4:    init_rom = 8'h01;
            3'd5:    init_rom = 8'h06;
            default: init_rom = 8'h38;
        endcase
    endfunction

    function automatic pins_t wr_pins(input logic rs, input logic [7:0] d, input logic e);
        wr_pins = '{e: e, rs: rs, rw: 1'b0, oe: 1'b1, d: d};
    endfunction

    // The three function-set writes precede a valid busy flag, so they always get the fixed clear delay.
    assign fixed_wait = !init_done && (rom_idx < 3'd3);

    always_comb begin
        wait_fin = (state == WAIT_DONE) && (cnt >= wait_len - 32'd1);
`ifdef LCD_BUSY_POLL_EN
        if (state == P_HOLD && cnt >= HOLD_TC && (!busy_smp || poll_cnt >= LIMIT_TC))
            wait_fin = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PWR_WAIT;
            pins        <= '0;
            cnt         <= '0;
            wait_len    <= '0;
            rom_idx     <= '0;
            lat_rs      <= 1'b0;
            lat_data    <= '0;
            cmd_ready   <= 1'b0;
            init_done   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt    <= '0;
            busy_smp    <= 1'b0;
`endif
        end else begin
            case (state)
                PWR_WAIT: begin
                    pins.rw <= 1'b1;
                    if (cnt >= PWRUP_TC) begin
                        cnt   <= '0;
                        state <= INIT_LOAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                INIT_LOAD: begin
                    lat_rs   <= 1'b0;
                    lat_data <= init_rom(rom_idx);
                    pins     <= wr_pins(1'b0, init_rom(rom_idx), 1'b0);
                    cnt      <= '0;
                    state    <= W_SETUP;
                end
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        lat_rs    <= cmd_rs;
                        lat_data  <= cmd_data;
                        pins      <= wr_pins(cmd_rs, cmd_data, 1'b0);
                        cmd_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    if (cnt >= SETUP_TC) begin
                        pins.e <= 1'b1;
                        cnt    <= '0;
                        state  <= W_EHI;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                W_EHI: begin
                    if (cnt >= EPW_TC) begin
                        pins.e <= 1'b0;
                        cnt    <= '0;
                        state  <= W_HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                W_HOLD: begin
                    if (cnt >= HOLD_TC) begin
                        cnt <= '0;
`ifdef LCD_BUSY_POLL_EN
                        if (fixed_wait) begin
                            pins     <= '{e: 1'b0, rs: pins.rs, rw: 1'b1, oe: 1'b0, d: pins.d};
                            wait_len <= 32'(T_CLEAR);
                            state    <= WAIT_DONE;
                        end else begin
                            pins     <= '{e: 1'b0, rs: 1'b0, rw: 1'b1, oe: 1'b0, d: pins.d};
                            poll_cnt <= '0;
                            state    <= P_SETUP;
                        end
`else
                        pins     <= '{e: 1'b0, rs: pins.rs, rw: 1'b1, oe: 1'b0, d: pins.d};
                        wait_len <= (fixed_wait || is_clear) ? 32'(T_CLEAR) : 32'(T_EXEC);
                        state    <= WAIT_DONE;
`endif
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!wait_fin)
                        cnt <= cnt + 32'd1;
                end
`ifdef LCD_BUSY_POLL_EN
                P_SETUP: begin
                    if (cnt >= SETUP_TC) begin
                        pins.e <= 1'b1;
                        cnt    <= '0;
                        state  <= P_EHI;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                P_EHI: begin
                    if (cnt >= EPW_TC) begin
                        busy_smp <= LCD_data_in[7];
                        pins.e   <= 1'b0;
                        cnt      <= '0;
                        state    <= P_HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                P_HOLD: begin
                    if (cnt >= HOLD_TC) begin
                        cnt <= '0;
                        // Still busy: either poll again or give up so the port cannot hang.
                        if (busy_smp) begin
                            if (poll_cnt >= LIMIT_TC) begin
                                timeout_err <= 1'b1;
                            end else begin
                                poll_cnt <= poll_cnt + 1'b1;
                                state    <= P_SETUP;
                            end
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`endif
                default: state <= PWR_WAIT;
            endcase

            if (wait_fin) begin
                cnt <= '0;
                if (init_done) begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end else if (rom_idx == 3'd5) begin
                    init_done <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end else begin
                    rom_idx <= rom_idx + 3'd1;
                    state   <= INIT_LOAD;
                end
            end
        end
    end

    assign LCD_E        = pins.e;
    assign LCD_RS       = pins.rs;
    assign LCD_RW       = pins.rw;
    assign LCD_data_oe  = pins.oe;
    assign LCD_data_out = pins.d;

endmodule

// File: tb/tb_lcd_16207_sequencer.sv
// Scoreboard bench for lcd_16207_sequencer: stimulus pushes expected pin transactions, a monitor measures strobes and waits.
module tb_lcd_16207_sequencer;
    localparam int T_PWRUP    = 10;
    localparam int T_SETUP    = 2;
    localparam int T_EPW      = 3;
    localparam int T_HOLD     = 2;
    localparam int T_EXEC     = 20;
    localparam int T_CLEAR    = 50;
    localparam int POLL_LIMIT = 5;
    localparam int BOUND      = 2000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       init_done;
    logic       timeout_err;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_data_out;
    logic       LCD_data_oe;
    logic [7:0] lcd_din;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         gap;
        int         reads;
        int         busy;
        logic       tout;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic       exp_tout = 1'b0;
    int         lcd_busy = 0;
    logic [7:0] init_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Panel model: DB7 reports busy until the requested number of read strobes has elapsed.
    assign lcd_din = {lcd_busy > 0, 7'h15};

    always #5 clk = ~clk;

    lcd_16207_sequencer #(
        .T_SETUP(T_SETUP), .T_EPW(T_EPW), .T_HOLD(T_HOLD), .T_PWRUP(T_PWRUP),
        .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
        .init_done(init_done), .timeout_err(timeout_err),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe), .LCD_data_in(lcd_din)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference model: completion wait derived from the byte class and the panel's busy behaviour.
    task automatic push_exp(input logic rs, input logic [7:0] d, input int init_idx, input int busy);
        exp_t e;
        e.rs = rs; e.d = d; e.busy = busy; e.reads = 0;
        if (init_idx >= 0 && init_idx < 3) begin
            e.gap = T_CLEAR;
        end else begin
`ifdef LCD_BUSY_POLL_EN
            int polls;
            polls = (busy + 1 > POLL_LIMIT) ? POLL_LIMIT : busy + 1;
            e.reads = polls;
            e.gap = polls * (T_SETUP + T_EPW + T_HOLD);
            if (busy >= POLL_LIMIT) exp_tout = 1'b1;
`else
            e.gap = (!rs && (d == 8'h01 || d == 8'h02)) ? T_CLEAR : T_EXEC;
`endif
        end
        if (init_idx >= 0 && init_idx < 5) e.gap++;  // load cycle before the next init byte
        e.tout = exp_tout;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t       r;
        bit         ab, stable, pe, have, pending;
        int         su, ep, ho, gap, rd;
        logic       rs0;
        logic [7:0] d0;
        pending = 0;
        forever begin
            if (!pending) @(negedge clk);
            pending = 0;
            if (reset_n && LCD_data_oe) begin
                have = exp_q.size() > 0;
                check("write_expected", have, 1);
                if (have) r = exp_q.pop_front();
                else r = '{rs: 1'b0, d: 8'h00, gap: 0, reads: 0, busy: 0, tout: 1'b0};
                lcd_busy = r.busy;
                rs0 = LCD_RS; d0 = LCD_data_out;
                ab = 0; stable = 1; pe = 0; su = 0; ep = 0; ho = 0; gap = 0; rd = 0;
                while (!ab && LCD_data_oe && !LCD_E && su < BOUND) begin
                    su++;
                    if (LCD_RS !== rs0 || LCD_data_out !== d0 || LCD_RW !== 1'b0) stable = 0;
                    @(negedge clk); if (!reset_n) ab = 1;
                end
                while (!ab && LCD_E && ep < BOUND) begin
                    ep++;
                    if (!LCD_data_oe || LCD_RS !== rs0 || LCD_data_out !== d0 || LCD_RW !== 1'b0) stable = 0;
                    @(negedge clk); if (!reset_n) ab = 1;
                end
                while (!ab && LCD_data_oe && !LCD_E && ho < BOUND) begin
                    ho++;
                    if (LCD_RS !== rs0 || LCD_data_out !== d0 || LCD_RW !== 1'b0) stable = 0;
                    @(negedge clk); if (!reset_n) ab = 1;
                end
                while (!ab && !LCD_data_oe && !cmd_ready && gap < BOUND) begin
                    if (LCD_E && !pe) begin
                        rd++;
                        if (LCD_RW !== 1'b1) stable = 0;
                    end
                    if (!LCD_E && pe && lcd_busy > 0) lcd_busy--;
                    pe = LCD_E; gap++;
                    @(negedge clk); if (!reset_n) ab = 1;
                end
                if (!ab) begin
                    check("write_rs_data", {rs0, d0}, {r.rs, r.d});
                    check("strobe_setup", su, T_SETUP);
                    check("strobe_e_high", ep, T_EPW);
                    check("strobe_hold", ho, T_HOLD);
                    check("lines_stable", stable, 1);
                    check("wait_gap", gap, r.gap);
                    check("busy_polls", rd, r.reads);
                    check("timeout_err", timeout_err, r.tout);
                    pending = LCD_data_oe;
                end
            end
        end
    end

    task automatic wait_init();
        int n = 0;
        bit early = 0;
        while (!init_done && n < 5000) begin
            @(negedge clk); n++;
            if (cmd_ready && !init_done) early = 1;
        end
        check("init_done", init_done, 1);
        check("no_ready_before_init", early, 0);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int busy);
        int n = 0;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin
            cmd_rs = 1'($urandom); cmd_data = 8'($urandom);
            @(negedge clk); n++;
        end
        check("cmd_ready_seen", cmd_ready, 1);
        cmd_rs = rs; cmd_data = d;
        push_exp(rs, d, -1, busy);
        @(negedge clk);
        check("ready_drops_after_accept", cmd_ready, 0);
        cmd_valid = 1'b0;
        cmd_data = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 5000) begin
            @(negedge clk); n++;
        end
        repeat (2) @(negedge clk);
        check("drained", {exp_q.size() == 0, cmd_ready}, 2'b11);
    endtask

    initial begin : stim
        int n;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
        for (int i = 0; i < 6; i++) push_exp(1'b0, init_bytes[i], i, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {cmd_ready, init_done, timeout_err, LCD_E, LCD_RS, LCD_RW, LCD_data_oe, LCD_data_out}, 0);
        reset_n = 1'b1;
        wait_init();

        send(1'b1, 8'h41, 3);
        send(1'b0, 8'h01, 0);
        send(1'b1, 8'h20, 0);
        send(1'b0, 8'h02, 1);
        send(1'b0, 8'h80, POLL_LIMIT);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                cmd_data = 8'($urandom);
            end
            send(1'($urandom), 8'($urandom), int'($urandom_range(0, POLL_LIMIT + 1)));
        end
        drain();

        send(1'b1, 8'h5A, 0);
        n = 0;
        while (!(LCD_E && !LCD_RW) && n < 200) begin
            @(negedge clk); n++;
        end
        check("saw_write_strobe", LCD_E, 1);
        #2 reset_n = 1'b0;
        #1 check("e_drops_async", LCD_E, 0);
        exp_q.delete();
        exp_tout = 1'b0;
        for (int i = 0; i < 6; i++) push_exp(1'b0, init_bytes[i], i, 0);
        repeat (3) @(negedge clk);
        check("reset_clears_status", {init_done, timeout_err, cmd_ready, LCD_data_oe}, 0);
        reset_n = 1'b1;
        wait_init();
        send(1'b1, 8'h33, 2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
